// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: single-beat stores and 1-4 beat load bursts over valid/ready,
// driving the memory address/write ports and returning read data on a response strobe.
module dmem_access_ctrl #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LAT_W = 2;
    localparam int unsigned BEAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_last;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic [BEAT_W-1:0]   r_beats_left;
    logic [LAT_W-1:0]    r_lat_cnt;

    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_resp_valid_nxt;
    logic                w_resp_last_nxt;
    logic [DATA_W-1:0]   w_resp_rdata_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_mem_we_nxt;
    logic [BEAT_W-1:0]   w_beats_left_nxt;
    logic [LAT_W-1:0]    w_lat_cnt_nxt;

    assign w_accept = req_valid && r_req_ready;

    // Next-state and next-register values; strobes default low, data registers hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_resp_valid_nxt = 1'b0;
        w_resp_last_nxt  = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_we_nxt     = 1'b0;
        w_beats_left_nxt = r_beats_left;
        w_lat_cnt_nxt    = r_lat_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mem_addr_nxt = req_addr;
                    if (req_we) begin
                        w_mem_wdata_nxt = req_wdata;
                        w_mem_we_nxt    = 1'b1;
                        w_state_nxt     = WRITE;
                    end else begin
                        w_beats_left_nxt = req_len;
                        w_lat_cnt_nxt    = LAT_RELOAD;
                        w_state_nxt      = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            READ_WAIT: begin
                if (r_lat_cnt == LAT_W'(0)) begin
                    w_resp_rdata_nxt = mem_rdata;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_last_nxt  = (r_beats_left == BEAT_W'(0));
                    if (r_beats_left != BEAT_W'(0)) begin
                        // Address wraps naturally at the ADDR_W boundary.
                        w_mem_addr_nxt   = r_mem_addr + ADDR_W'(1);
                        w_beats_left_nxt = r_beats_left - BEAT_W'(1);
                        w_lat_cnt_nxt    = LAT_RELOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_beats_left <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_last  <= w_resp_last_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_last  = r_resp_last;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: one controller with READ_LATENCY=1 and one with READ_LATENCY=3 share a
// byte memory model; stores go through the latency-1 controller.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rq_we;
    logic [7:0] rq_addr;
    logic [7:0] rq_wdata;
    logic [1:0] rq_len;
    logic       v1, v3;

    logic       rdy1, rv1, rl1, we1;
    logic [7:0] rd1, ma1, mw1, mr1;
    logic       rdy3, rv3, rl3, we3;
    logic [7:0] rd3, ma3, mw3, mr3;

    logic [7:0] mem [256];
    logic [7:0] p3_0, p3_1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.READ_LATENCY(1), .ADDR_W(8), .DATA_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(rq_we),
        .req_addr(rq_addr), .req_wdata(rq_wdata), .req_len(rq_len),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_last(rl1),
        .mem_addr(ma1), .mem_wdata(mw1), .mem_we(we1), .mem_rdata(mr1)
    );

    dmem_access_ctrl #(.READ_LATENCY(3), .ADDR_W(8), .DATA_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(rq_we),
        .req_addr(rq_addr), .req_wdata(rq_wdata), .req_len(rq_len),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_last(rl3),
        .mem_addr(ma3), .mem_wdata(mw3), .mem_we(we3), .mem_rdata(mr3)
    );

    // Memory: latency 1 is a same-cycle read, latency 3 adds two register stages.
    always_ff @(posedge clk) begin
        if (we1) mem[ma1] <= mw1;
        p3_0 <= mem[ma3];
        p3_1 <= p3_0;
    end
    assign mr1 = mem[ma1];
    assign mr3 = p3_1;

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        int t = 0;
        while (!rdy1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rdy1 !== 1'b1) $display("FAIL store_ready_wait: ready=%b required 1", rdy1);
        else n_pass++;
        rq_we = 1'b1; rq_addr = a; rq_wdata = d; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; rq_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL reset_ready: got %b required 1", rdy1); else n_pass++;
        n_checks++; if (rv1 !== 1'b0) $display("FAIL reset_resp_valid: got %b required 0", rv1); else n_pass++;
        n_checks++; if (rl1 !== 1'b0) $display("FAIL reset_resp_last: got %b required 0", rl1); else n_pass++;
        n_checks++; if (rd1 !== 8'h00) $display("FAIL reset_resp_rdata: got %h required 00", rd1); else n_pass++;
        n_checks++; if (ma1 !== 8'h00) $display("FAIL reset_mem_addr: got %h required 00", ma1); else n_pass++;
        n_checks++; if (mw1 !== 8'h00) $display("FAIL reset_mem_wdata: got %h required 00", mw1); else n_pass++;
        n_checks++; if (we1 !== 1'b0) $display("FAIL reset_mem_we: got %b required 0", we1); else n_pass++;
        n_checks++; if (rdy3 !== 1'b1 || mw3 !== 8'h00) $display("FAIL reset_dut3: ready=%b wdata=%h required 1/00", rdy3, mw3); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_store;
        rq_we = 1'b1; rq_addr = 8'h10; rq_wdata = 8'hA5; rq_len = 2'd3; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        n_checks++; if (we1 !== 1'b1) $display("FAIL store_we_c1: got %b required 1", we1); else n_pass++;
        n_checks++; if (ma1 !== 8'h10) $display("FAIL store_addr_c1: got %h required 10", ma1); else n_pass++;
        n_checks++; if (mw1 !== 8'hA5) $display("FAIL store_wdata_c1: got %h required a5", mw1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b0) $display("FAIL store_ready_c1: got %b required 0", rdy1); else n_pass++;
        n_checks++; if (rv1 !== 1'b0) $display("FAIL store_resp_c1: got %b required 0", rv1); else n_pass++;
        @(negedge clk);
        rq_we = 1'b0; rq_len = 2'd0;
        n_checks++; if (we1 !== 1'b0) $display("FAIL store_we_c2: got %b required 0", we1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL store_ready_c2: got %b required 1", rdy1); else n_pass++;
        n_checks++; if (rv1 !== 1'b0) $display("FAIL store_resp_c2: got %b required 0", rv1); else n_pass++;
        n_checks++; if (ma1 !== 8'h10 || mw1 !== 8'hA5) $display("FAIL store_hold_c2: addr=%h wdata=%h required 10/a5", ma1, mw1); else n_pass++;
    endtask

    task automatic test_store_load;
        do_store(8'h20, 8'h3C);
        rq_we = 1'b0; rq_addr = 8'h20; rq_len = 2'd0; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        n_checks++; if (rv1 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL load1_c1: valid=%b ready=%b required 0/0", rv1, rdy1); else n_pass++;
        n_checks++; if (ma1 !== 8'h20) $display("FAIL load1_addr_c1: got %h required 20", ma1); else n_pass++;
        @(negedge clk);
        n_checks++; if (rv1 !== 1'b1) $display("FAIL load1_valid_c2: got %b required 1", rv1); else n_pass++;
        n_checks++; if (rd1 !== 8'h3C) $display("FAIL load1_rdata_c2: got %h required 3c", rd1); else n_pass++;
        n_checks++; if (rl1 !== 1'b1) $display("FAIL load1_last_c2: got %b required 1", rl1); else n_pass++;
        @(negedge clk);
        n_checks++; if (rv1 !== 1'b0 || rl1 !== 1'b0) $display("FAIL load1_c3: valid=%b last=%b required 0/0", rv1, rl1); else n_pass++;
        n_checks++; if (rd1 !== 8'h3C || rdy1 !== 1'b1) $display("FAIL load1_hold_c3: rdata=%h ready=%b required 3c/1", rd1, rdy1); else n_pass++;
    endtask

    task automatic test_burst_wrap;
        logic [7:0] exp_addr [4];
        logic [7:0] exp_data [4];
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) do_store(exp_addr[i], exp_data[i]);
        rq_we = 1'b0; rq_addr = 8'hFE; rq_len = 2'd3; v1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            v1 = 1'b0;
            if (c <= 4) begin
                n_checks++;
                if (ma1 !== exp_addr[c-1]) $display("FAIL burst_addr_c%0d: got %h required %h", c, ma1, exp_addr[c-1]);
                else n_pass++;
            end
            n_checks++;
            if (rv1 !== (c >= 2 && c <= 5)) $display("FAIL burst_valid_c%0d: got %b required %b", c, rv1, (c >= 2 && c <= 5));
            else n_pass++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (rd1 !== exp_data[c-2] || rl1 !== (c == 5))
                    $display("FAIL burst_beat_c%0d: rdata=%h last=%b required %h/%b", c, rd1, rl1, exp_data[c-2], (c == 5));
                else n_pass++;
            end else begin
                n_checks++;
                if (rl1 !== 1'b0) $display("FAIL burst_last_idle_c%0d: got %b required 0", c, rl1); else n_pass++;
            end
        end
    endtask

    task automatic test_latency3;
        int we_seen = 0;
        do_store(8'h40, 8'h5A);
        do_store(8'h41, 8'hC3);
        rq_we = 1'b0; rq_addr = 8'h40; rq_len = 2'd1; v3 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            v3 = 1'b0;
            if (we3) we_seen++;
            n_checks++;
            if (rv3 !== (c == 4 || c == 7)) $display("FAIL lat3_valid_c%0d: got %b required %b", c, rv3, (c == 4 || c == 7));
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (rd3 !== 8'h5A || rl3 !== 1'b0) $display("FAIL lat3_beat0: rdata=%h last=%b required 5a/0", rd3, rl3); else n_pass++;
            end
            if (c == 7) begin
                n_checks++;
                if (rd3 !== 8'hC3 || rl3 !== 1'b1) $display("FAIL lat3_beat1: rdata=%h last=%b required c3/1", rd3, rl3); else n_pass++;
            end
        end
        n_checks++; if (rdy3 !== 1'b1) $display("FAIL lat3_ready_end: got %b required 1", rdy3); else n_pass++;
        n_checks++; if (we_seen != 0) $display("FAIL lat3_no_write: mem_we cycles=%0d required 0", we_seen); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic exp_rdy [4];
        int strobes = 0;
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_store(8'h21, 8'h77);
        rq_we = 1'b0; rq_addr = 8'h20; rq_len = 2'd1; v1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (rv1) strobes++;
            if (c <= 4) begin
                n_checks++;
                if (rdy1 !== exp_rdy[c-1]) $display("FAIL b2b_ready_c%0d: got %b required %b", c, rdy1, exp_rdy[c-1]);
                else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (ma1 !== 8'h20) $display("FAIL b2b_second_addr: got %h required 20", ma1); else n_pass++;
                v1 = 1'b0;
            end
        end
        n_checks++; if (strobes != 4) $display("FAIL b2b_strobes: got %0d required 4", strobes); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL b2b_ready_end: got %b required 1", rdy1); else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        int strobes = 0;
        rq_we = 1'b0; rq_addr = 8'hFE; rq_len = 2'd3; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        n_checks++; if (rv1 !== 1'b1 || rd1 !== 8'h11) $display("FAIL rstmid_first_beat: valid=%b rdata=%h required 1/11", rv1, rd1); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rdy1 !== 1'b1 || rv1 !== 1'b0) $display("FAIL rstmid_idle: ready=%b valid=%b required 1/0", rdy1, rv1); else n_pass++;
        n_checks++; if (ma1 !== 8'h00 || we1 !== 1'b0) $display("FAIL rstmid_mem: addr=%h we=%b required 00/0", ma1, we1); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv1) strobes++;
        end
        n_checks++; if (strobes != 0) $display("FAIL rstmid_no_resp: strobes=%0d required 0", strobes); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; v1 = 1'b0; v3 = 1'b0;
        rq_we = 1'b0; rq_addr = 8'h00; rq_wdata = 8'h00; rq_len = 2'd0;
        test_reset();
        test_store();
        test_store_load();
        test_burst_wrap();
        test_latency3();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
